serial_subtractor: RTL and testbench

//  Multi-cycle N-bit subtractor computing D = A - B - Bin and final borrow Bo.

---
 rtl/serial_subtractor.sv | 137 +++++++++++++
 tb/tb_serial_subtractor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: D = A - B - Bin, DIGIT bits per clock, LSB first, with valid/ready handshakes.
// Optional build macro SERSUB_SAT_EN clamps d to zero when the final borrow is set.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG) + 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_n;
    logic [WIDTH-1:0] a_r, a_n;
    logic [WIDTH-1:0] b_r, b_n;
    logic [WIDTH-1:0] d_r, d_n;
    logic             borrow_r, borrow_n;
    logic             bo_r, bo_n;
    logic             out_valid_r, out_valid_n;
    logic [CW-1:0]    count_r, count_n;
    logic [DIGIT:0]   slice_diff_s;
    logic [WIDTH-1:0] slice_ext_s;

    // One DIGIT-wide ripple-borrow slice; the extra top bit is the borrow out of the slice.
    always_comb begin
        slice_diff_s = {1'b0, a_r[DIGIT-1:0]} - {1'b0, b_r[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_r};
        slice_ext_s  = '0;
        slice_ext_s[DIGIT-1:0] = slice_diff_s[DIGIT-1:0];
    end

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_n     = state_r;
        a_n         = a_r;
        b_n         = b_r;
        d_n         = d_r;
        borrow_n    = borrow_r;
        bo_n        = bo_r;
        out_valid_n = out_valid_r;
        count_n     = count_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    a_n      = a;
                    b_n      = b;
                    borrow_n = bin;
                    count_n  = '0;
                    state_n  = RUN;
                end else begin
                    state_n  = IDLE;
                end
            end
            RUN: begin
                // Result digits enter at the MSB so d is LSB-aligned after the last digit.
                a_n      = a_r >> DIGIT;
                b_n      = b_r >> DIGIT;
                d_n      = (d_r >> DIGIT) | (slice_ext_s << (WIDTH - DIGIT));
                borrow_n = slice_diff_s[DIGIT];
                count_n  = count_r + CW'(1);
                if (count_r == LAST) begin
                    bo_n        = slice_diff_s[DIGIT];
                    out_valid_n = 1'b1;
                    state_n     = DONE;
`ifdef SERSUB_SAT_EN
                    if (slice_diff_s[DIGIT]) begin
                        d_n = '0;
                    end else begin
                        d_n = (d_r >> DIGIT) | (slice_ext_s << (WIDTH - DIGIT));
                    end
`endif
                end else begin
                    state_n = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end else begin
                    state_n     = DONE;
                end
            end
            default: begin
                state_n     = IDLE;
                out_valid_n = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            d_r         <= '0;
            borrow_r    <= 1'b0;
            bo_r        <= 1'b0;
            out_valid_r <= 1'b0;
            count_r     <= '0;
        end else begin
            state_r     <= state_n;
            a_r         <= a_n;
            b_r         <= b_n;
            d_r         <= d_n;
            borrow_r    <= borrow_n;
            bo_r        <= bo_n;
            out_valid_r <= out_valid_n;
            count_r     <= count_n;
        end
    end

    assign in_ready  = (state_r == IDLE) && !rst;
    assign busy      = (state_r == RUN) || (state_r == DONE);
    assign out_valid = out_valid_r;
    assign d         = d_r;
    assign bo        = bo_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (DIGIT=1 and DIGIT=4 instances) with a result scoreboard.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_valid4;
    logic       in_ready, in_ready4;
    logic [7:0] a, b, a4, b4;
    logic       bin, bin4;
    logic       out_valid, out_valid4;
    logic       out_ready, out_ready4;
    logic [7:0] d, d4;
    logic       bo, bo4;
    logic       busy, busy4;

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] sb_q[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .bo(bo), .busy(busy)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .d(d4), .bo(bo4), .busy(busy4)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one operation on the selected instance; all timing is referenced to negedges.
    task automatic run_op(input bit w4, input logic [7:0] ta, input logic [7:0] tbv,
                          input logic tbin, input int hold);
        logic [8:0] full;
        logic [8:0] exp;
        logic [7:0] d_seen;
        logic       bo_seen;
        logic       ov;
        int         n;
        full = {1'b0, ta} - {1'b0, tbv} - {8'd0, tbin};
        exp  = full;
`ifdef SERSUB_SAT_EN
        if (full[8]) exp[7:0] = 8'h00;
`endif
        sb_q.push_back(exp);
        check_eq("in_ready_idle", 32'(w4 ? in_ready4 : in_ready), 32'd1);
        if (w4) begin
            a4 = ta; b4 = tbv; bin4 = tbin; in_valid4 = 1'b1;
        end else begin
            a = ta; b = tbv; bin = tbin; in_valid = 1'b1;
        end
        tick();
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        check_eq("busy_run", 32'(w4 ? busy4 : busy), 32'd1);
        check_eq("in_ready_run", 32'(w4 ? in_ready4 : in_ready), 32'd0);
        n  = 0;
        ov = 1'b0;
        while (!ov && n < 64) begin
            tick();
            n++;
            ov = w4 ? out_valid4 : out_valid;
        end
        check_eq("latency", 32'(n), w4 ? 32'd2 : 32'd8);
        d_seen  = w4 ? d4 : d;
        bo_seen = w4 ? bo4 : bo;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            check_eq("d", 32'(d_seen), 32'(exp[7:0]));
            check_eq("bo", 32'(bo_seen), 32'(exp[8]));
        end
        // Stall in DONE while offering new operands that must be ignored.
        for (int i = 0; i < hold; i++) begin
            if (w4) begin
                a4 = ~ta; b4 = 8'h01; in_valid4 = 1'b1;
            end else begin
                a = ~ta; b = 8'h01; in_valid = 1'b1;
            end
            tick();
            check_eq("hold_d", 32'(w4 ? d4 : d), 32'(d_seen));
            check_eq("hold_bo", 32'(w4 ? bo4 : bo), 32'(bo_seen));
            check_eq("hold_valid", 32'(w4 ? out_valid4 : out_valid), 32'd1);
            check_eq("hold_in_ready", 32'(w4 ? in_ready4 : in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        if (w4) out_ready4 = 1'b1; else out_ready = 1'b1;
        tick();
        out_ready  = 1'b0;
        out_ready4 = 1'b0;
        check_eq("post_valid", 32'(w4 ? out_valid4 : out_valid), 32'd0);
        check_eq("post_in_ready", 32'(w4 ? in_ready4 : in_ready), 32'd1);
        check_eq("post_busy", 32'(w4 ? busy4 : busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_valid4 = 1'b0;
        out_ready = 1'b0; out_ready4 = 1'b0;
        a = 8'h00; b = 8'h00; bin = 1'b0;
        a4 = 8'h00; b4 = 8'h00; bin4 = 1'b0;
        tick();
        tick();
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_d", 32'(d), 32'd0);
        check_eq("rst_bo", 32'(bo), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rel_in_ready", 32'(in_ready), 32'd1);

        run_op(1'b0, 8'h35, 8'h12, 1'b0, 0);
        run_op(1'b0, 8'h00, 8'h01, 1'b0, 0);
        run_op(1'b0, 8'h80, 8'h7F, 1'b1, 0);
        run_op(1'b0, 8'h10, 8'h10, 1'b1, 0);
        run_op(1'b0, 8'h00, 8'h00, 1'b0, 0);
        run_op(1'b0, 8'hC3, 8'h5D, 1'b1, 5);

        // Abort mid-RUN with reset: no result may appear.
        a = 8'h77; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_eq("abort_in_ready", 32'(in_ready), 32'd0);
        tick();
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_d", 32'(d), 32'd0);
        check_eq("abort_bo", 32'(bo), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("abort_idle_busy", 32'(busy), 32'd0);
        run_op(1'b0, 8'h9A, 8'h2B, 1'b0, 0);

        run_op(1'b1, 8'hA5, 8'h5A, 1'b0, 0);
        run_op(1'b1, 8'h10, 8'h10, 1'b1, 2);

        for (int i = 0; i < 10; i++) begin
            run_op(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
            run_op(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
